// File: rtl/pool_engine_pkg.sv
// Shared definitions for the window pooling engine.
//  - pool_mode_e : reduction mode encodings (reserved code behaves as MIN)
//  - ST_*        : FSM state constants
//  - DEF_DW/AW   : default data and address widths
//  - sum_width() : accumulator width needed for an exact K*K-element sum
package pool_engine_pkg;

    typedef enum logic [1:0] {
        MODE_MIN  = 2'b00,
        MODE_MAX  = 2'b01,
        MODE_SUM  = 2'b10,
        MODE_RSVD = 2'b11
    } pool_mode_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int DEF_DW = 24;
    localparam int DEF_AW = 18;

    // Summing K*K signed DW-bit values cannot overflow DW + clog2(K*K) bits.
    function automatic int sum_width(input int dw, input int k);
        return dw + $clog2(k * k);
    endfunction

endpackage

// File: rtl/pool_engine_if.sv
// RAM-side bus of the pooling engine.
//  IF RAM    : RAM_IF_OE / RAM_IF_A from the engine, RAM_IF_Q back (valid the cycle after OE)
//  RESULT RAM: RAM_RESULT_WE / RAM_RESULT_A / RAM_RESULT_D from the engine
//  master modport = engine side, slave modport = memory side.
interface pool_engine_if
    import pool_engine_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
);
    logic          RAM_IF_OE;
    logic [AW-1:0] RAM_IF_A;
    logic [DW-1:0] RAM_IF_Q;
    logic          RAM_RESULT_WE;
    logic [AW-1:0] RAM_RESULT_A;
    logic [DW-1:0] RAM_RESULT_D;

    modport master (
        output RAM_IF_OE,
        output RAM_IF_A,
        input  RAM_IF_Q,
        output RAM_RESULT_WE,
        output RAM_RESULT_A,
        output RAM_RESULT_D
    );

    modport slave (
        input  RAM_IF_OE,
        input  RAM_IF_A,
        output RAM_IF_Q,
        input  RAM_RESULT_WE,
        input  RAM_RESULT_A,
        input  RAM_RESULT_D
    );
endinterface

// File: rtl/pool_engine_reduce.sv
// Window accumulator for the pooling engine.
//  clk, rst   : clock, asynchronous active-low reset (clears the accumulator)
//  fold_en    : register the folded value this cycle
//  first      : q is the first element of a window (load instead of reduce)
//  mode       : MIN / MAX / SUM (reserved code acts as MIN)
//  q          : incoming signed pixel
//  result     : combinational fold of acc with q, saturated to DW bits for SUM
module pool_engine_reduce
    import pool_engine_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int K  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fold_en,
    input  logic          first,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] q,
    output logic [DW-1:0] result
);
    localparam int SW = sum_width(DW, K);

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    logic signed [SW-1:0] acc_reg;
    logic signed [SW-1:0] acc_next;
    logic signed [SW-1:0] q_ext;

    assign q_ext = SW'($signed(q));

    always_comb begin
        acc_next = acc_reg;
        if (first) begin
            acc_next = q_ext;
        end else begin
            case (pool_mode_e'(mode))
                MODE_MAX: acc_next = (q_ext > acc_reg) ? q_ext : acc_reg;
                MODE_SUM: acc_next = acc_reg + q_ext;
                default:  acc_next = (q_ext < acc_reg) ? q_ext : acc_reg;
            endcase
        end
    end

    // MIN/MAX values always fit in DW bits; only SUM can need clamping.
    always_comb begin
        result = acc_next[DW-1:0];
        if (pool_mode_e'(mode) == MODE_SUM) begin
            if (acc_next > SAT_MAX) begin
                result = SAT_MAX[DW-1:0];
            end else if (acc_next < SAT_MIN) begin
                result = SAT_MIN[DW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg <= '0;
        end else if (fold_en) begin
            acc_reg <= acc_next;
        end
    end
endmodule

// File: rtl/pool_engine.sv
// 2-D window pooling engine.
// Reads CH planes of IMG_H x IMG_W signed pixels, slides a KxK window with step
// STRIDE and writes one MIN/MAX/saturated-SUM value per window to the RESULT RAM.
//  clk, rst           : clock, asynchronous active-low reset
//  start              : begin a run (accepted only in IDLE or DONE)
//  mode               : 00 MIN, 01 MAX, 10 SUM, 11 MIN; latched at start
//  if_base, res_base  : IF plane-0 base and RESULT base; latched at start
//  ram                : RAM bus (master modport)
//  busy               : run in progress
//  done               : level, high in DONE until the next accepted start
// Each window takes K*K read cycles plus one write cycle.
module pool_engine
    import pool_engine_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int CH     = 1,
    parameter int K      = 2,
    parameter int STRIDE = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] if_base,
    input  logic [AW-1:0] res_base,
    pool_engine_if.master ram,
    output logic          busy,
    output logic          done
);
    localparam int OW = (IMG_W - K) / STRIDE + 1;
    localparam int OH = (IMG_H - K) / STRIDE + 1;

    generate
        if (K < 1 || K > IMG_W || K > IMG_H) begin : g_bad_k
            $error("pool_engine: K out of range");
        end
        if (STRIDE < 1) begin : g_bad_stride
            $error("pool_engine: STRIDE must be >= 1");
        end
        if (CH < 1) begin : g_bad_ch
            $error("pool_engine: CH must be >= 1");
        end
        if (64'(CH) * 64'(IMG_W) * 64'(IMG_H) > (64'd1 << AW)) begin : g_bad_aw
            $error("pool_engine: image does not fit the address space");
        end
    endgenerate

    localparam logic [AW-1:0] ONE     = AW'(1);
    localparam logic [AW-1:0] K_LAST  = AW'(K - 1);
    localparam logic [AW-1:0] OW_LAST = AW'(OW - 1);
    localparam logic [AW-1:0] OH_LAST = AW'(OH - 1);
    localparam logic [AW-1:0] CH_LAST = AW'(CH - 1);
    localparam logic [AW-1:0] W_A     = AW'(IMG_W);
    localparam logic [AW-1:0] S_A     = AW'(STRIDE);
    localparam logic [AW-1:0] PLANE_A = AW'(IMG_W * IMG_H);
    localparam logic [AW-1:0] OW_A    = AW'(OW);
    localparam logic [AW-1:0] OHW_A   = AW'(OH * OW);

    logic [1:0]    state_reg,    state_next;
    logic [AW-1:0] kx_reg,       kx_next;
    logic [AW-1:0] ky_reg,       ky_next;
    logic [AW-1:0] ox_reg,       ox_next;
    logic [AW-1:0] oy_reg,       oy_next;
    logic [AW-1:0] c_reg,        c_next;
    logic [1:0]    mode_reg,     mode_next;
    logic [AW-1:0] if_base_reg,  if_base_next;
    logic [AW-1:0] res_base_reg, res_base_next;
    logic          first_reg,    first_next;
    logic          q_valid_reg,  q_valid_next;

    logic          rd_active;
    logic          wr_active;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] result;

    assign rd_active = (state_reg == ST_READ);
    assign wr_active = (state_reg == ST_WRITE);

    always_comb begin
        state_next    = state_reg;
        kx_next       = kx_reg;
        ky_next       = ky_reg;
        ox_next       = ox_reg;
        oy_next       = oy_reg;
        c_next        = c_reg;
        mode_next     = mode_reg;
        if_base_next  = if_base_reg;
        res_base_next = res_base_reg;
        first_next    = first_reg;
        q_valid_next  = rd_active;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next    = ST_READ;
                    kx_next       = '0;
                    ky_next       = '0;
                    ox_next       = '0;
                    oy_next       = '0;
                    c_next        = '0;
                    mode_next     = mode;
                    if_base_next  = if_base;
                    res_base_next = res_base;
                    first_next    = 1'b1;
                end
            end
            ST_READ: begin
                // A fold happens whenever the previous cycle issued a read.
                if (q_valid_reg) begin
                    first_next = 1'b0;
                end
                if (kx_reg == K_LAST) begin
                    kx_next = '0;
                    if (ky_reg == K_LAST) begin
                        ky_next    = '0;
                        state_next = ST_WRITE;
                    end else begin
                        ky_next = ky_reg + ONE;
                    end
                end else begin
                    kx_next = kx_reg + ONE;
                end
            end
            default: begin
                // ST_WRITE: step to the next window, ox fastest, then oy, then c.
                first_next = 1'b1;
                state_next = ST_READ;
                if (ox_reg == OW_LAST) begin
                    ox_next = '0;
                    if (oy_reg == OH_LAST) begin
                        oy_next = '0;
                        if (c_reg == CH_LAST) begin
                            c_next     = '0;
                            state_next = ST_DONE;
                        end else begin
                            c_next = c_reg + ONE;
                        end
                    end else begin
                        oy_next = oy_reg + ONE;
                    end
                end else begin
                    ox_next = ox_reg + ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            kx_reg       <= '0;
            ky_reg       <= '0;
            ox_reg       <= '0;
            oy_reg       <= '0;
            c_reg        <= '0;
            mode_reg     <= '0;
            if_base_reg  <= '0;
            res_base_reg <= '0;
            first_reg    <= 1'b0;
            q_valid_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            kx_reg       <= kx_next;
            ky_reg       <= ky_next;
            ox_reg       <= ox_next;
            oy_reg       <= oy_next;
            c_reg        <= c_next;
            mode_reg     <= mode_next;
            if_base_reg  <= if_base_next;
            res_base_reg <= res_base_next;
            first_reg    <= first_next;
            q_valid_reg  <= q_valid_next;
        end
    end

    assign rd_addr = if_base_reg + c_reg * PLANE_A + (oy_reg * S_A + ky_reg) * W_A
                   + ox_reg * S_A + kx_reg;
    assign wr_addr = res_base_reg + c_reg * OHW_A + oy_reg * OW_A + ox_reg;

    // During WRITE the last pixel of the window is folded combinationally,
    // so only READ cycles update the stored accumulator.
    pool_engine_reduce #(
        .DW (DW),
        .K  (K)
    ) u_reduce (
        .clk     (clk),
        .rst     (rst),
        .fold_en (rd_active && q_valid_reg),
        .first   (first_reg),
        .mode    (mode_reg),
        .q       (ram.RAM_IF_Q),
        .result  (result)
    );

    // Buses are forced to zero whenever their strobe is low.
    assign ram.RAM_IF_OE     = rd_active;
    assign ram.RAM_IF_A      = rd_active ? rd_addr : '0;
    assign ram.RAM_RESULT_WE = wr_active;
    assign ram.RAM_RESULT_A  = wr_active ? wr_addr : '0;
    assign ram.RAM_RESULT_D  = wr_active ? result  : '0;

    assign busy = rd_active || wr_active;
    assign done = (state_reg == ST_DONE);
endmodule

// File: tb/tb_pool_engine.sv
module tb_pool_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_a, start_b;
    logic [1:0]  mode_a, mode_b;
    logic [17:0] if_base_a, res_base_a, if_base_b, res_base_b;
    logic        busy_a, done_a, busy_b, done_b;

    int total;
    int bad;
    int col4_hits;
    int oob_hits;

    logic [23:0] mem_a [64];
    logic [23:0] mem_b [64];

    typedef struct packed {
        logic [17:0] addr;
        logic [23:0] data;
    } wr_t;

    typedef struct packed {
        logic [1:0]        mode;
        logic [1:0]        fill;
        logic [17:0]       res_base;
        logic [0:3][23:0]  exp;
    } vec_t;

    wr_t  exp_q_a[$];
    wr_t  exp_q_b[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    pool_engine_if #(.DW(24), .AW(18)) bus_a ();
    pool_engine_if #(.DW(24), .AW(18)) bus_b ();

    pool_engine #(
        .DW(24), .AW(18), .IMG_W(4), .IMG_H(4), .CH(1), .K(2), .STRIDE(2)
    ) dut_a (
        .clk(clk), .rst(rst_n), .start(start_a), .mode(mode_a),
        .if_base(if_base_a), .res_base(res_base_a), .ram(bus_a),
        .busy(busy_a), .done(done_a)
    );

    pool_engine #(
        .DW(24), .AW(18), .IMG_W(5), .IMG_H(4), .CH(2), .K(2), .STRIDE(2)
    ) dut_b (
        .clk(clk), .rst(rst_n), .start(start_b), .mode(mode_b),
        .if_base(if_base_b), .res_base(res_base_b), .ram(bus_b),
        .busy(busy_b), .done(done_b)
    );

    // IF RAM models: registered read, data valid the cycle after OE.
    always @(posedge clk) begin
        if (bus_a.RAM_IF_OE) bus_a.RAM_IF_Q <= mem_a[bus_a.RAM_IF_A[5:0]];
        if (bus_b.RAM_IF_OE) bus_b.RAM_IF_Q <= mem_b[bus_b.RAM_IF_A[5:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [63:0] outs_a();
        return {bus_a.RAM_IF_OE, bus_a.RAM_IF_A, bus_a.RAM_RESULT_WE, bus_a.RAM_RESULT_A,
                bus_a.RAM_RESULT_D, busy_a, done_a};
    endfunction

    function automatic logic [63:0] outs_b();
        return {bus_b.RAM_IF_OE, bus_b.RAM_IF_A, bus_b.RAM_RESULT_WE, bus_b.RAM_RESULT_A,
                bus_b.RAM_RESULT_D, busy_b, done_b};
    endfunction

    // Scoreboard monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("a_oe_we_excl", 64'(bus_a.RAM_IF_OE && bus_a.RAM_RESULT_WE), 64'd0);
            if (bus_a.RAM_RESULT_WE) begin
                $display("a write addr=%0d data=%06h", bus_a.RAM_RESULT_A, bus_a.RAM_RESULT_D);
                if (exp_q_a.size() == 0) begin
                    check("a_unexpected_wr", 64'd1, 64'd0);
                end else begin
                    check("a_wr", 64'({bus_a.RAM_RESULT_A, bus_a.RAM_RESULT_D}),
                          64'(exp_q_a.pop_front()));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("b_oe_we_excl", 64'(bus_b.RAM_IF_OE && bus_b.RAM_RESULT_WE), 64'd0);
            if (bus_b.RAM_IF_OE) begin
                if ((bus_b.RAM_IF_A % 5) == 4) col4_hits++;
                if (bus_b.RAM_IF_A >= 40) oob_hits++;
            end
            if (bus_b.RAM_RESULT_WE) begin
                $display("b write addr=%0d data=%06h", bus_b.RAM_RESULT_A, bus_b.RAM_RESULT_D);
                if (exp_q_b.size() == 0) begin
                    check("b_unexpected_wr", 64'd1, 64'd0);
                end else begin
                    check("b_wr", 64'({bus_b.RAM_RESULT_A, bus_b.RAM_RESULT_D}),
                          64'(exp_q_b.pop_front()));
                end
            end
        end
    end

    function automatic vec_t make_vec(input logic [1:0] m, input logic [1:0] f,
                                      input logic [17:0] rb, input logic [23:0] e0,
                                      input logic [23:0] e1, input logic [23:0] e2,
                                      input logic [23:0] e3);
        vec_t v;
        v.mode = m; v.fill = f; v.res_base = rb;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic fill_a(input logic [1:0] kind);
        for (int i = 0; i < 16; i++) begin
            case (kind)
                2'd0:    mem_a[i] = 24'(i);
                2'd1:    mem_a[i] = 24'h7FFFFF;
                2'd2:    mem_a[i] = 24'h800000;
                default: mem_a[i] = 24'(-i);
            endcase
        end
    endtask

    // One full run on instance A; optionally pulses start (with altered mode/base) mid-run.
    task automatic run_a(input vec_t v, input bit pulse_mid, input int tag);
        int cyc;
        fill_a(v.fill);
        mode_a = v.mode;
        res_base_a = v.res_base;
        for (int i = 0; i < 4; i++) exp_q_a.push_back({18'(v.res_base + 18'(i)), v.exp[i]});
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("a_start_ack", 64'({done_a, busy_a}), 64'd1);
        cyc = 0;
        while (!done_a && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pulse_mid && cyc == 3) begin
                start_a = 1'b1;
                mode_a = 2'd2;
                res_base_a = 18'd300;
            end else if (cyc == 4) begin
                start_a = 1'b0;
            end
        end
        $display("a run %0d mode=%0d cycles=%0d", tag, v.mode, cyc);
        check("a_cycles", 64'(cyc), 64'd20);
        check("a_all_writes", 64'(exp_q_a.size()), 64'd0);
        check("a_end_state", 64'({done_a, busy_a}), 64'd2);
        exp_q_a.delete();
    endtask

    initial begin
        int cyc;
        total = 0;
        bad = 0;
        col4_hits = 0;
        oob_hits = 0;
        rst_n = 1'b0;
        start_a = 1'b0; start_b = 1'b0;
        mode_a = 2'd0; mode_b = 2'd0;
        if_base_a = '0; res_base_a = '0; if_base_b = '0; res_base_b = '0;
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = '0;
            mem_b[i] = 24'(i);
        end

        vecs[0] = make_vec(2'd0, 2'd0, 18'd0,  24'd0, 24'd2, 24'd8, 24'd10);
        vecs[1] = make_vec(2'd1, 2'd0, 18'd16, 24'd5, 24'd7, 24'd13, 24'd15);
        vecs[2] = make_vec(2'd2, 2'd0, 18'd32, 24'd10, 24'd18, 24'd42, 24'd50);
        vecs[3] = make_vec(2'd2, 2'd1, 18'd4,  24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);
        vecs[4] = make_vec(2'd2, 2'd2, 18'd8,  24'h800000, 24'h800000, 24'h800000, 24'h800000);
        vecs[5] = make_vec(2'd1, 2'd3, 18'd40, 24'h000000, 24'hFFFFFE, 24'hFFFFF8, 24'hFFFFF6);
        vecs[6] = make_vec(2'd0, 2'd3, 18'd44, 24'hFFFFFB, 24'hFFFFF9, 24'hFFFFF3, 24'hFFFFF1);
        vecs[7] = make_vec(2'd2, 2'd3, 18'd48, 24'hFFFFF6, 24'hFFFFEE, 24'hFFFFD6, 24'hFFFFCE);
        vecs[8] = make_vec(2'd3, 2'd0, 18'd52, 24'd0, 24'd2, 24'd8, 24'd10);
        vecs[9] = make_vec(2'd1, 2'd1, 18'd56, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF);

        #1;
        check("a_reset_outputs", outs_a(), 64'd0);
        check("b_reset_outputs", outs_b(), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("a_idle_outputs", outs_a(), 64'd0);

        for (int i = 0; i < 10; i++) run_a(vecs[i], 1'b0, i);

        // start pulsed while busy, with new mode/base: must not disturb the run
        run_a(vecs[0], 1'b1, 100);

        // reset asserted during a READ of window 1
        fill_a(2'd0);
        mode_a = 2'd0;
        res_base_a = 18'd0;
        exp_q_a.push_back({18'd0, 24'd0});
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        cyc = 0;
        while (cyc < 7) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("a_in_window1_read", 64'(bus_a.RAM_IF_OE), 64'd1);
        rst_n = 1'b0;
        #1;
        check("a_rst_async_outputs", outs_a(), 64'd0);
        @(posedge clk);
        #1;
        check("a_rst_next_edge_outputs", outs_a(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("a_rst_writes_seen", 64'(exp_q_a.size()), 64'd0);
        exp_q_a.delete();
        run_a(vecs[0], 1'b0, 101);

        // Instance B: 5x4 planes, two channels, MAX
        mode_b = 2'd1;
        res_base_b = 18'd200;
        exp_q_b.push_back({18'd200, 24'd6});
        exp_q_b.push_back({18'd201, 24'd8});
        exp_q_b.push_back({18'd202, 24'd16});
        exp_q_b.push_back({18'd203, 24'd18});
        exp_q_b.push_back({18'd204, 24'd26});
        exp_q_b.push_back({18'd205, 24'd28});
        exp_q_b.push_back({18'd206, 24'd36});
        exp_q_b.push_back({18'd207, 24'd38});
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        cyc = 0;
        while (!done_b && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        $display("b run mode=1 cycles=%0d", cyc);
        check("b_cycles", 64'(cyc), 64'd40);
        check("b_all_writes", 64'(exp_q_b.size()), 64'd0);
        check("b_col4_reads", 64'(col4_hits), 64'd0);
        check("b_oob_reads", 64'(oob_hits), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
